// File: rtl/keypoint_axis_tx.sv
// keypoint_axis_tx
// Packs the per-pixel keypoint decisions of the extreme-detection pipeline
// into an AXI4-Stream packet. Each accepted keypoint becomes one coordinate
// word {1'b0, row[14:0], col[15:0]}. Each frame closes with one trailer word
// {1'b1, drop_flag, count[29:0]} that has tlast set.
//
// Ports:
//   axi_clk, axi_rst        clock, asynchronous active-high reset
//   key_valid, key_mark     one pulse per pixel in raster order, keypoint flag
//   m_axis_tdata/tvalid/tlast/tready   AXI4-Stream master
//   key_overflow            sticky: some keypoint was dropped since reset
//
// Optional build macro KEYPOINT_TX_DROP_FLAG_EN: when it is defined, trailer
// bit 30 reports whether any keypoint of that frame was dropped. When it is
// not defined, bit 30 is always 0.
module keypoint_axis_tx #(
    parameter int IMAGE_COLUMN = 512,
    parameter int IMAGE_ROW    = 512,
    parameter int FIFO_DEPTH   = 64
) (
    input  logic        axi_clk,
    input  logic        axi_rst,
    input  logic        key_valid,
    input  logic        key_mark,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic        key_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    // Raster position and the one-stage input register
    logic [15:0] col;
    logic [14:0] row;
    logic        last_col, last_px;
    logic        kp_stg, eof_stg;
    logic [31:0] kp_word;

    assign last_col = (col == 16'(IMAGE_COLUMN - 1));
    assign last_px  = last_col && (row == 15'(IMAGE_ROW - 1));

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            col     <= '0;
            row     <= '0;
            kp_stg  <= 1'b0;
            eof_stg <= 1'b0;
            kp_word <= '0;
        end else begin
            kp_stg  <= key_valid && key_mark;
            eof_stg <= key_valid && last_px;
            if (key_valid) begin
                kp_word <= {1'b0, row, col};
                if (last_col) begin
                    col <= '0;
                    row <= last_px ? '0 : row + 15'd1;
                end else begin
                    col <= col + 16'd1;
                end
            end
        end
    end

    // FIFO: the tlast bit is stored next to the data
    logic [32:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, wr_en, kp_acc, kp_drop, tr_wr;
    logic [32:0]   wr_data;

    logic          trailer_pending;
    logic [29:0]   frame_cnt, trailer_cnt, cnt_next;
    logic          trailer_flag;

    assign full = (count == (AW+1)'(FIFO_DEPTH));
    assign pop  = m_axis_tvalid && m_axis_tready;

    // Keep one slot free so that the trailer always fits behind the keypoints.
    assign kp_acc  = kp_stg && (count <= (AW+1)'(FIFO_DEPTH - 2)) && !trailer_pending;
    assign kp_drop = kp_stg && !kp_acc;
    assign tr_wr   = trailer_pending && !full && !kp_acc;
    assign wr_en   = kp_acc || tr_wr;
    assign wr_data = kp_acc ? {1'b0, kp_word}
                            : {1'b1, 1'b1, trailer_flag, trailer_cnt};

    // This count includes the keypoint handled this cycle. When the last pixel
    // of a frame is a keypoint, the trailer snapshot then includes it.
    assign cnt_next = (kp_acc && frame_cnt != '1) ? frame_cnt + 30'd1 : frame_cnt;

    always_ff @(posedge axi_clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            trailer_pending <= 1'b0;
            trailer_cnt     <= '0;
            frame_cnt       <= '0;
            key_overflow    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            count        <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
            key_overflow <= key_overflow | kp_drop;
            if (tr_wr) trailer_pending <= 1'b0;
            if (eof_stg) begin
                trailer_pending <= 1'b1;
                trailer_cnt     <= cnt_next;
                frame_cnt       <= '0;
            end else begin
                frame_cnt       <= cnt_next;
            end
        end
    end

`ifdef KEYPOINT_TX_DROP_FLAG_EN
    logic frame_drop, trailer_drop;
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            frame_drop   <= 1'b0;
            trailer_drop <= 1'b0;
        end else if (eof_stg) begin
            trailer_drop <= frame_drop | kp_drop;
            frame_drop   <= 1'b0;
        end else begin
            frame_drop   <= frame_drop | kp_drop;
        end
    end
    assign trailer_flag = trailer_drop;
`else
    assign trailer_flag = 1'b0;
`endif

    // First-word-fall-through output. The head entry only changes on a pop,
    // so the outputs stay stable while the sink stalls.
    assign m_axis_tvalid = (count != '0);
    assign {m_axis_tlast, m_axis_tdata} = m_axis_tvalid ? mem[rd_ptr] : 33'd0;

endmodule

// File: tb/tb_keypoint_axis_tx.sv
module tb_keypoint_axis_tx;
    logic        clk = 1'b0;
    logic        rst, kv, km, tready;
    logic [31:0] tdata;
    logic        tvalid, tlast, ovf;

    int checks = 0;
    int failures = 0;

    keypoint_axis_tx #(.IMAGE_COLUMN(8), .IMAGE_ROW(4), .FIFO_DEPTH(4)) dut (
        .axi_clk(clk), .axi_rst(rst), .key_valid(kv), .key_mark(km),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast),
        .m_axis_tready(tready), .key_overflow(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    // Collect every word that handshakes. Inputs change at posedge+1, so
    // the values seen at negedge are the ones the next edge acts on.
    logic [32:0] q[$];
    always @(negedge clk) if (!rst && tvalid && tready) q.push_back({tlast, tdata});

    // While the sink stalls, the outputs must hold their values.
    logic        stalled = 1'b0;
    logic [32:0] held = '0;
    always @(negedge clk) begin
        if (!rst && stalled) chk("stall_hold", 64'({tvalid, tlast, tdata}), 64'({1'b1, held}));
        stalled <= !rst && tvalid && !tready;
        held    <= {tlast, tdata};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input logic [31:0] mask, input bit rnd);
        for (int p = 0; p < 32; p++) begin
            kv = 1'b1;
            km = mask[p];
            if (rnd) tready = 1'($urandom_range(0, 1));
            step();
        end
        kv = 1'b0;
        km = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int b = 0;
        while (q.size() < n && b < 200) begin
            step();
            b++;
        end
        repeat (4) step();
    endtask

    typedef struct packed {
        logic [31:0]      mask;
        logic [2:0]       n;
        logic [3:0][32:0] w;
    } vec_t;

    vec_t tv[4];
    logic [31:0] masks[3];
    logic [32:0] w;
    int fr, ncoord, last_pos, pos;
    logic [32:0] trl3;

    initial begin
        // Pixel index = row*8 + col. A word is {tlast, tdata}.
        tv[0] = '{mask: 32'h8000_0400, n: 3'd3,
                  w: {33'h0_0000_0000, 33'h1_8000_0002, 33'h0_0003_0007, 33'h0_0001_0002}};
        tv[1] = '{mask: 32'h0, n: 3'd1,
                  w: {33'h0, 33'h0, 33'h0, 33'h1_8000_0000}};
        tv[2] = '{mask: 32'h0020_0001, n: 3'd3,
                  w: {33'h0, 33'h1_8000_0002, 33'h0_0002_0005, 33'h0_0000_0000}};
        tv[3] = '{mask: 32'h0000_0080, n: 3'd2,
                  w: {33'h0, 33'h0, 33'h1_8000_0001, 33'h0_0000_0007}};

        rst = 1'b1; kv = 1'b0; km = 1'b0; tready = 1'b0;
        repeat (3) step();
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tlast", 64'(tlast), 64'd0);
        chk("rst_tdata", 64'(tdata), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        rst = 1'b0;
        step();

        // Table-driven frames with tready=1
        tready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            q.delete();
            drive_frame(tv[t].mask, 1'b0);
            wait_words(int'(tv[t].n));
            chk($sformatf("frame%0d_nwords", t), 64'(q.size()), 64'(tv[t].n));
            for (int i = 0; i < int'(tv[t].n); i++)
                chk($sformatf("frame%0d_word%0d", t, i),
                    (i < q.size()) ? 64'(q[i]) : 64'hxxxx, 64'(tv[t].w[i]));
        end
        chk("no_ovf_yet", 64'(ovf), 64'd0);

        // Keypoint latency: written one edge after sampling, visible after that.
        q.delete();
        tready = 1'b0;
        kv = 1'b1; km = 1'b1;
        step();
        km = 1'b0;
        chk("kp_lat_e1_tvalid", 64'(tvalid), 64'd0);
        step();
        chk("kp_lat_e2_tvalid", 64'(tvalid), 64'd1);
        chk("kp_lat_e2_word", 64'({tlast, tdata}), 64'h0_0000_0000);
        for (int p = 2; p < 32; p++) step();
        kv = 1'b0;
        tready = 1'b1;
        wait_words(2);
        chk("kp_lat_nwords", 64'(q.size()), 64'd2);
        chk("kp_lat_trailer", (q.size() > 1) ? 64'(q[1]) : 64'hxxxx, 64'h1_8000_0001);

        // Empty frame: the trailer appears 2 edges after the last key_valid.
        q.delete();
        tready = 1'b0;
        for (int p = 0; p < 31; p++) begin kv = 1'b1; km = 1'b0; step(); end
        kv = 1'b1;
        step();
        kv = 1'b0;
        chk("trl_lat_e1", 64'(tvalid), 64'd0);
        step();
        chk("trl_lat_e2", 64'(tvalid), 64'd0);
        step();
        chk("trl_lat_e3_tvalid", 64'(tvalid), 64'd1);
        chk("trl_lat_e3_word", 64'({tlast, tdata}), 64'h1_8000_0000);
        tready = 1'b1;
        step();
        chk("trl_lat_nwords", 64'(q.size()), 64'd1);
        step();

        // Overflow: 5 keypoints while stalled with depth 4 -> 3 accepted
        q.delete();
        tready = 1'b0;
        drive_frame(32'h0000_001F, 1'b0);
        repeat (3) step();
        chk("ovf_sticky", 64'(ovf), 64'd1);
`ifdef KEYPOINT_TX_DROP_FLAG_EN
        trl3 = 33'h1_C000_0003;
`else
        trl3 = 33'h1_8000_0003;
`endif
        tready = 1'b1;
        wait_words(4);
        chk("ovf_nwords", 64'(q.size()), 64'd4);
        chk("ovf_w0", (q.size() > 0) ? 64'(q[0]) : 64'hxxxx, 64'h0_0000_0000);
        chk("ovf_w1", (q.size() > 1) ? 64'(q[1]) : 64'hxxxx, 64'h0_0000_0001);
        chk("ovf_w2", (q.size() > 2) ? 64'(q[2]) : 64'hxxxx, 64'h0_0000_0002);
        chk("ovf_trailer", (q.size() > 3) ? 64'(q[3]) : 64'hxxxx, 64'(trl3));

        // Random backpressure across 3 dense frames
        q.delete();
        for (int f = 0; f < 3; f++) masks[f] = $urandom | $urandom;
        for (int f = 0; f < 3; f++) drive_frame(masks[f], 1'b1);
        tready = 1'b1;
        repeat (30) step();
        fr = 0; ncoord = 0; last_pos = -1;
        foreach (q[i]) begin
            w = q[i];
            if (w[32]) begin
                chk("rnd_trl_bit31", 64'(w[31]), 64'd1);
                chk("rnd_trl_count", 64'(w[29:0]), 64'(ncoord));
                fr++; ncoord = 0; last_pos = -1;
            end else begin
                pos = int'(w[30:16]) * 8 + int'(w[15:0]);
                chk("rnd_coord_ok",
                    64'(fr < 3 && w[15:0] < 8 && pos < 32 && pos > last_pos
                        && masks[fr < 3 ? fr : 0][pos < 32 ? pos : 0]), 64'd1);
                last_pos = pos;
                ncoord++;
            end
        end
        chk("rnd_frames", 64'(fr), 64'd3);
        chk("rnd_tail_empty", 64'(ncoord), 64'd0);

        // Reset mid-frame with 2 words queued
        q.delete();
        tready = 1'b0;
        drive_frame(32'h0, 1'b0);   // realign, trailer stays queued
        tready = 1'b1;
        repeat (4) step();
        tready = 1'b0;
        q.delete();
        for (int p = 0; p < 5; p++) begin kv = 1'b1; km = (p < 2); step(); end
        kv = 1'b0; km = 1'b0;
        chk("pre_rst_tvalid", 64'(tvalid), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_tvalid", 64'(tvalid), 64'd0);
        step();
        chk("rst_next_tvalid", 64'(tvalid), 64'd0);
        chk("rst_ovf_clear", 64'(ovf), 64'd0);
        rst = 1'b0;
        step();
        q.delete();
        tready = 1'b1;
        drive_frame(32'h0008_0000, 1'b0);
        wait_words(2);
        chk("post_rst_nwords", 64'(q.size()), 64'd2);
        chk("post_rst_w0", (q.size() > 0) ? 64'(q[0]) : 64'hxxxx, 64'h0_0002_0003);
        chk("post_rst_trl", (q.size() > 1) ? 64'(q[1]) : 64'hxxxx, 64'h1_8000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
